// File: rtl/fpga_clk_cfg_arbiter.sv
// Round-robin arbiter sharing one clock-manager DRP port between the soc, per and cluster
// config requesters, with MMCM reset/relock sequencing after a commit write.
module fpga_clk_cfg_arbiter #(
    parameter int unsigned RDY_TIMEOUT  = 64,
    parameter int unsigned RST_CYCLES   = 4,
    parameter int unsigned LOCK_TIMEOUT = 1024,
    parameter logic [31:0] ERR_DATA     = 32'hdeadda7a
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        soc_cfg_req_i,
    input  logic [1:0]  soc_cfg_add_i,
    input  logic [31:0] soc_cfg_data_i,
    input  logic        soc_cfg_wrn_i,
    output logic        soc_cfg_ack_o,
    output logic [31:0] soc_cfg_r_data_o,
    output logic        soc_cfg_lock_o,

    input  logic        per_cfg_req_i,
    input  logic [1:0]  per_cfg_add_i,
    input  logic [31:0] per_cfg_data_i,
    input  logic        per_cfg_wrn_i,
    output logic        per_cfg_ack_o,
    output logic [31:0] per_cfg_r_data_o,
    output logic        per_cfg_lock_o,

    input  logic        cluster_cfg_req_i,
    input  logic [1:0]  cluster_cfg_add_i,
    input  logic [31:0] cluster_cfg_data_i,
    input  logic        cluster_cfg_wrn_i,
    output logic        cluster_cfg_ack_o,
    output logic [31:0] cluster_cfg_r_data_o,
    output logic        cluster_cfg_lock_o,

    output logic        drp_en_o,
    output logic        drp_we_o,
    output logic [3:0]  drp_addr_o,
    output logic [31:0] drp_wdata_o,
    input  logic        drp_rdy_i,
    input  logic [31:0] drp_rdata_i,

    input  logic        mmcm_locked_i,
    output logic        mmcm_rst_o,
    output logic        err_o
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_RDY  = 3'd2;
    localparam logic [2:0] S_RESP      = 3'd3;
    localparam logic [2:0] S_MMCM_RST  = 3'd4;
    localparam logic [2:0] S_WAIT_LOCK = 3'd5;

    localparam int unsigned CNT_MAX_A = (RDY_TIMEOUT > RST_CYCLES) ? RDY_TIMEOUT : RST_CYCLES;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT) ? CNT_MAX_A : LOCK_TIMEOUT;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_prio;
    logic [1:0]       r_port;
    logic             r_wrn;
    logic             r_commit;
    logic [2:0]       r_ack;
    logic [31:0]      r_rdata [3];
    logic             r_lock;
    logic             r_drp_en;
    logic             r_drp_we;
    logic [3:0]       r_drp_addr;
    logic [31:0]      r_drp_wdata;
    logic             r_mmcm_rst;
    logic             r_err;

    logic [2:0]       w_req;
    logic [1:0]       w_p1;
    logic [1:0]       w_p2;
    logic             w_grant_vld;
    logic [1:0]       w_grant_port;
    logic [1:0]       w_sel_add;
    logic [31:0]      w_sel_data;
    logic             w_sel_wrn;
    logic             w_rdy_done;
    logic             w_rdy_to;
    logic             w_rst_done;
    logic             w_lock_to;

    function automatic logic [1:0] f_next(input logic [1:0] p);
        f_next = (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Round-robin pick: lowest-priority candidate first so the highest one wins
    always_comb begin
        w_req        = {cluster_cfg_req_i, per_cfg_req_i, soc_cfg_req_i};
        w_p1         = f_next(r_prio);
        w_p2         = f_next(w_p1);
        w_grant_vld  = |w_req;
        w_grant_port = r_prio;
        if (w_req[w_p2])   w_grant_port = w_p2;
        if (w_req[w_p1])   w_grant_port = w_p1;
        if (w_req[r_prio]) w_grant_port = r_prio;

        w_sel_add  = soc_cfg_add_i;
        w_sel_data = soc_cfg_data_i;
        w_sel_wrn  = soc_cfg_wrn_i;
        case (w_grant_port)
            2'd1: begin
                w_sel_add  = per_cfg_add_i;
                w_sel_data = per_cfg_data_i;
                w_sel_wrn  = per_cfg_wrn_i;
            end
            2'd2: begin
                w_sel_add  = cluster_cfg_add_i;
                w_sel_data = cluster_cfg_data_i;
                w_sel_wrn  = cluster_cfg_wrn_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_rdy_done  = (r_state == S_WAIT_RDY) && drp_rdy_i;
        w_rdy_to    = (r_state == S_WAIT_RDY) && !drp_rdy_i
                      && (r_cnt == CNT_W'(RDY_TIMEOUT - 1));
        w_rst_done  = (r_state == S_MMCM_RST) && (r_cnt == CNT_W'(RST_CYCLES - 1));
        w_lock_to   = (r_state == S_WAIT_LOCK) && !mmcm_locked_i
                      && (r_cnt == CNT_W'(LOCK_TIMEOUT - 1));

        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (w_grant_vld) w_state_nxt = S_ISSUE;
            S_ISSUE:     w_state_nxt = S_WAIT_RDY;
            S_WAIT_RDY:  if (w_rdy_done || w_rdy_to) w_state_nxt = S_RESP;
            S_RESP:      w_state_nxt = r_commit ? S_MMCM_RST : S_IDLE;
            S_MMCM_RST:  if (w_rst_done) w_state_nxt = S_WAIT_LOCK;
            S_WAIT_LOCK: if (mmcm_locked_i || w_lock_to) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Datapath and registered outputs; everything is derived from the next state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt       <= '0;
            r_prio      <= 2'd0;
            r_port      <= 2'd0;
            r_wrn       <= 1'b0;
            r_commit    <= 1'b0;
            r_ack       <= '0;
            for (int i = 0; i < 3; i++) r_rdata[i] <= '0;
            r_lock      <= 1'b0;
            r_drp_en    <= 1'b0;
            r_drp_we    <= 1'b0;
            r_drp_addr  <= '0;
            r_drp_wdata <= '0;
            r_mmcm_rst  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_state_nxt != r_state)
                r_cnt <= '0;
            else if (r_state == S_WAIT_RDY || r_state == S_MMCM_RST || r_state == S_WAIT_LOCK)
                r_cnt <= r_cnt + CNT_W'(1);

            if (r_state == S_IDLE && w_grant_vld) begin
                r_port      <= w_grant_port;
                r_wrn       <= w_sel_wrn;
                r_drp_addr  <= {w_grant_port, w_sel_add};
                r_drp_wdata <= w_sel_data;
                r_prio      <= f_next(w_grant_port);
            end

            r_drp_en <= (w_state_nxt == S_ISSUE);
            case (w_state_nxt)
                S_ISSUE:    r_drp_we <= !w_sel_wrn;
                S_WAIT_RDY: r_drp_we <= !r_wrn;
                default:    r_drp_we <= 1'b0;
            endcase

            r_ack <= '0;
            if (w_state_nxt == S_RESP) r_ack[r_port] <= 1'b1;

            if (w_rdy_done && r_wrn) r_rdata[r_port] <= drp_rdata_i;
            if (w_rdy_to)            r_rdata[r_port] <= ERR_DATA;

            // Only a confirmed write to the commit register restarts the clock manager
            if (w_rdy_done || w_rdy_to)
                r_commit <= w_rdy_done && !r_wrn && (r_drp_addr[1:0] == 2'b11);

            if (w_rdy_to || w_lock_to) r_err <= 1'b1;

            r_mmcm_rst <= (w_state_nxt == S_MMCM_RST);
            r_lock     <= mmcm_locked_i && (r_state != S_MMCM_RST) && (r_state != S_WAIT_LOCK);
        end
    end

    assign soc_cfg_ack_o        = r_ack[0];
    assign per_cfg_ack_o        = r_ack[1];
    assign cluster_cfg_ack_o    = r_ack[2];
    assign soc_cfg_r_data_o     = r_rdata[0];
    assign per_cfg_r_data_o     = r_rdata[1];
    assign cluster_cfg_r_data_o = r_rdata[2];
    assign soc_cfg_lock_o       = r_lock;
    assign per_cfg_lock_o       = r_lock;
    assign cluster_cfg_lock_o   = r_lock;
    assign drp_en_o             = r_drp_en;
    assign drp_we_o             = r_drp_we;
    assign drp_addr_o           = r_drp_addr;
    assign drp_wdata_o          = r_drp_wdata;
    assign mmcm_rst_o           = r_mmcm_rst;
    assign err_o                = r_err;

endmodule

// File: doc/fpga_clk_cfg_arbiter.md
FPGA_CLK_CFG_ARBITER -- requirements
Module: fpga_clk_cfg_arbiter

Interface
REQ-001 Parameters SHALL be:
- RDY_TIMEOUT, 64, max WAIT_RDY cycles before forced completion
- RST_CYCLES, 4, mmcm_rst_o pulse width in cycles
- LOCK_TIMEOUT, 1024, max WAIT_LOCK cycles
- ERR_DATA, 32'hdeadda7a, read data returned on timeout
REQ-002 Ports SHALL be (name direction width meaning):
- clk_i in 1 single clock; all logic on its rising edge
- rst_i in 1 synchronous active-high reset
- {soc,per,cluster}_cfg_req_i in 1 request, held until ack
- {soc,per,cluster}_cfg_add_i in 2 register address
- {soc,per,cluster}_cfg_data_i in 32 write data
- {soc,per,cluster}_cfg_wrn_i in 1 1=read, 0=write
- {soc,per,cluster}_cfg_ack_o out 1 one-cycle completion pulse
- {soc,per,cluster}_cfg_r_data_o out 32 read data
- {soc,per,cluster}_cfg_lock_o out 1 clock locked and usable
- drp_en_o out 1 one-cycle access strobe to clock manager
- drp_we_o out 1 write strobe qualifier
- drp_addr_o out 4 {port_sel[1:0], add[1:0]}; soc=0, per=1, cluster=2
- drp_wdata_o out 32 write data
- drp_rdy_i in 1 access done
- drp_rdata_i in 32 read data, valid with drp_rdy_i
- mmcm_locked_i in 1 clock manager lock
- mmcm_rst_o out 1 clock manager reset
- err_o out 1 sticky timeout flag

Function
REQ-003 States SHALL be IDLE, ISSUE, WAIT_RDY, RESP, MMCM_RST, WAIT_LOCK.
REQ-004 IDLE: if any req high, grant by round-robin, latch port/add/data/wrn, go ISSUE; else stay.
REQ-005 Round-robin: priority order starts soc>per>cluster after reset; after grant to port i, port (i+1) mod 3 becomes highest.
REQ-006 ISSUE: drp_en_o=1 for exactly one cycle, drp_we_o=~wrn, drp_addr_o/drp_wdata_o from latched values; go WAIT_RDY.
REQ-007 drp_addr_o/drp_wdata_o/drp_we_o SHALL stay stable from ISSUE until leaving WAIT_RDY; drp_we_o=0 whenever drp_en_o=0 outside that window.
REQ-008 WAIT_RDY: drp_rdy_i sampled only here; on rdy capture drp_rdata_i (reads) and go RESP; counter increments per cycle; on reaching RDY_TIMEOUT without rdy, capture ERR_DATA, set err_o, go RESP.
REQ-009 RESP: granted port's ack_o=1 for one cycle; its r_data_o updated in this cycle (reads and timeouts only) and held until its next read ack; other ports' outputs unchanged.
REQ-010 Minimum latency: req seen in IDLE cycle 0, en in cycle 1, rdy in cycle 2 -> ack in cycle 3.
REQ-011 Requester SHALL drop req the cycle after ack; arbiter never samples req in RESP, so no double grant.
REQ-012 Exit RESP: write to add=2'b11 completed with rdy (not timeout) -> MMCM_RST; otherwise -> IDLE.
REQ-013 MMCM_RST: mmcm_rst_o=1 for exactly RST_CYCLES cycles, then WAIT_LOCK.
REQ-014 WAIT_LOCK: go IDLE when mmcm_locked_i=1; if LOCK_TIMEOUT cycles elapse, set err_o and go IDLE.
REQ-015 x_cfg_lock_o = mmcm_locked_i AND state not in {MMCM_RST, WAIT_LOCK}, registered (one-cycle latency), same for all ports.
REQ-016 Requests arriving during MMCM_RST/WAIT_LOCK SHALL wait; none are lost or acked early.
REQ-017 Counters SHALL be wide enough for the largest parameter and SHALL clear on every state entry.

Reset
REQ-018 While rst_i=1 at a clock edge: state=IDLE, priority=soc, all ack_o=0, r_data_o=0, lock_o=0, drp_en_o=0, drp_we_o=0, drp_addr_o=0, drp_wdata_o=0, mmcm_rst_o=0, err_o=0, counters=0.
REQ-019 Reset mid-transaction SHALL abandon it with no ack issued; requester re-requests.

Verification
REQ-020 Single read: per req, add=1, wrn=1; rdy+rdata=32'h12345678 one cycle after en -> drp_addr_o=4'b0101, per ack at cycle 3, per_cfg_r_data_o=32'h12345678.
REQ-021 Contention: all three req same cycle after reset -> grants soc, per, cluster in order, exactly one ack each, no overlap.
REQ-022 Timeout: rdy never asserted -> ack after RDY_TIMEOUT cycles in WAIT_RDY, r_data=32'hdeadda7a, err_o=1 until reset.
REQ-023 Commit: soc write add=2'b11 -> ack, mmcm_rst_o high 4 cycles, all lock_o low, pending cluster req granted only after mmcm_locked_i rises.
REQ-024 Lock timeout: mmcm_locked_i held 0 after commit -> after 1024 cycles err_o=1, state IDLE, next request serviced.
REQ-025 Reset in WAIT_RDY: rst_i pulsed -> no ack, all outputs at REQ-018 values next cycle.
